cpu_trace_ctrl: RTL and testbench
=================================

# cpu_trace_ctrl

Parametrised run controller and trace buffer for the single-cycle MIPS core. It sequences the core's reset and enables the core. It captures one record per executed cycle (PC, instruction, ALU result, write-back data) into a DEPTH-entry FIFO, which an external sink drains with a valid/ready handshake. A run stops on a halt instruction or a cycle limit, and the FIFO can either back-pressure the core or wrap.

## Interface
- XLEN, 32: width of every traced field and of cycle_count.
- DEPTH, 16: trace FIFO entries; power of two, at least 2.
- RESET_CYCLES, 2: cycles core_reset is held in RESET state; at least 1.
- MAX_CYCLES, 1000: executed-cycle limit per run; at least 1.
- HALT_INSTR, 32'h0000000C: instruction word that ends a run (syscall).
- WRAP_MODE, 0: 0 = stall core when FIFO full; 1 = overwrite oldest entry.

Ports:
- clk  in  1  system clock, rising edge.
- pc_reset_n  in  1  asynchronous, active-low reset of the whole block.
- start  in  1  one-cycle run request.
- core_reset  out  1  active-high reset to core (drives mips_cpu pc_reset).
- core_en  out  1  core clock enable; core state advances only when high.
- pc, instr, alu_result, wb_data  in  XLEN each  core's current-cycle values.
- trace_valid  out  1  FIFO non-empty.
- trace_ready  in  1  sink accepts head record.
- trace_pc, trace_instr, trace_alu, trace_wb  out  XLEN each  head record.
- busy  out  1  state is RESET or RUN.
- done  out  1  state is DONE.
- halt_cause  out  2  00 none, 01 halt instruction, 10 cycle limit.
- cycle_count  out  XLEN  executed cycles in current/last run.
- trace_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky; one or more records overwritten (WRAP_MODE=1 only).

## Operation
- States: IDLE, RESET, RUN, DONE.
- Reset values: IDLE, core_reset=1, core_en=0, FIFO empty, trace_valid=0, busy=0, done=0, halt_cause=00, cycle_count=0, overflow=0, trace fields 0.
- IDLE/DONE + start:
  - Go to RESET.
  - Clear cycle_count, halt_cause and overflow.
  - FIFO contents are kept.
- start in RESET or RUN is ignored.
- RESET:
  - core_reset=1, core_en=1 for exactly RESET_CYCLES cycles.
  - Then go to RUN.
- RUN:
  - core_reset=0.
  - core_en = !full || trace_ready || WRAP_MODE. This is a combinational path from trace_ready, and it is intended.
  - Each cycle with core_en=1:
    - Push {pc, instr, alu_result, wb_data}.
    - cycle_count += 1.
  - Halt check on enabled cycles, in priority order:
    - instr==HALT_INSTR gives cause 01.
    - Otherwise cycle_count==MAX_CYCLES-1 gives cause 10.
    - On a halt, the record is still pushed and the state goes to DONE next edge.
- DONE: core_en=0, core_reset=0, done=1. The core holds its final state for inspection.
- FIFO:
  - First-word fall-through; trace_* show the head whenever trace_valid=1.
  - A pop occurs on trace_valid && trace_ready, in any state.
- Full with push and pop in the same cycle: both happen, occupancy is unchanged, and core_en=1.
- WRAP_MODE=1, push while full with no pop: drop the oldest record, write the new one, set overflow. Occupancy stays DEPTH.
- WRAP_MODE=0, full with no pop: core_en=0 and cycle_count holds. There is no loss and no overflow.
- Pop when empty: no effect. Pointers wrap modulo DEPTH.

## Timing
- start sampled at edge N: RESET from N+1; RUN from N+1+RESET_CYCLES.
- Trace latency: a record pushed at edge E has trace_valid=1 after E (one cycle) if the FIFO was empty.
- Halt: the cycle carrying the halt instruction or the last allowed cycle is recorded. From the next edge: done=1, core_en=0, halt_cause valid.
- MAX_CYCLES run ends with cycle_count=MAX_CYCLES.
- pc_reset_n asserted at any time, including mid-RUN or a mid-handshake pop:
  - All outputs go to reset values immediately, without waiting for clk.
  - FIFO is emptied.
  - Release is synchronous to the next clk edge.

## Test plan
- Reset: pc_reset_n=0 mid-RUN -> immediately core_reset=1, core_en=0, trace_valid=0, trace_count=0, cycle_count=0, busy=0, done=0.
- Basic run (RESET_CYCLES=2, trace_ready=1), start at cycle 0:
  - core_reset=1 during cycles 1-2; RUN from cycle 3.
  - pc 0,4,8 appear on trace_pc in order, one cycle after capture.
- Halt instruction: instr=0000000C on the 6th RUN cycle -> that record appears in the trace; next cycle done=1, halt_cause=01, cycle_count=6, core_en=0.
- Stall (WRAP_MODE=0, DEPTH=4, trace_ready=0):
  - After 4 records, core_en=0 and cycle_count holds at 4.
  - trace_ready=1 for one cycle -> one pop, one push, core_en=1 that cycle, trace_count=4.
- Wrap (WRAP_MODE=1, DEPTH=4, trace_ready=0, pc=0,4,...,20 over 6 cycles):
  - overflow=1, trace_count=4.
  - Draining yields pc 8,12,16,20.
- Limit (MAX_CYCLES=8, no halt instruction) -> done after 8 RUN cycles, halt_cause=10, cycle_count=8. A second start from DONE restarts with cycle_count=0 and halt_cause=00.

Source files
------------

// File: rtl/cpu_trace_ctrl_if.sv
// Trace stream between cpu_trace_ctrl (master) and the record sink (slave).
// Valid/ready handshake with the head record presented alongside valid.
interface cpu_trace_ctrl_if #(
  parameter int XLEN = 32
);
  logic            trace_valid;
  logic            trace_ready;
  logic [XLEN-1:0] trace_pc;
  logic [XLEN-1:0] trace_instr;
  logic [XLEN-1:0] trace_alu;
  logic [XLEN-1:0] trace_wb;

  modport master (
    output trace_valid, trace_pc, trace_instr, trace_alu, trace_wb,
    input  trace_ready
  );

  modport slave (
    input  trace_valid, trace_pc, trace_instr, trace_alu, trace_wb,
    output trace_ready
  );
endinterface

// File: rtl/cpu_trace_ctrl.sv
// Run controller and trace FIFO for the single-cycle MIPS core: sequences core reset,
// gates the core clock enable and captures one record per executed cycle.
//
// state   | meaning
// IDLE    | after reset; core held in reset, waiting for start
// RESET   | core_reset and core_en high for RESET_CYCLES cycles
// RUN     | core executing; one trace record pushed per enabled cycle
// DONE    | halted (instruction or cycle limit); core frozen for inspection
module cpu_trace_ctrl #(
  parameter int              XLEN         = 32,
  parameter int              DEPTH        = 16,
  parameter int              RESET_CYCLES = 2,
  parameter int              MAX_CYCLES   = 1000,
  parameter logic [XLEN-1:0] HALT_INSTR   = XLEN'('hC),
  parameter bit              WRAP_MODE    = 1'b0
) (
  input  logic                       clk,
  input  logic                       pc_reset_n,
  input  logic                       start,
  output logic                       core_reset,
  output logic                       core_en,
  input  logic [XLEN-1:0]            pc,
  input  logic [XLEN-1:0]            instr,
  input  logic [XLEN-1:0]            alu_result,
  input  logic [XLEN-1:0]            wb_data,
  cpu_trace_ctrl_if.master           trace,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 halt_cause,
  output logic [XLEN-1:0]            cycle_count,
  output logic [$clog2(DEPTH):0]     trace_count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [XLEN-1:0]   cycle_count_q, cycle_count_d;
  logic [1:0]        halt_cause_q, halt_cause_d;
  logic              overflow_q, overflow_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [4*XLEN-1:0] mem_q [DEPTH];
  logic [4*XLEN-1:0] head;

  logic full, empty, pop, push, drop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty && trace.trace_ready;

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cycle_count_d = cycle_count_q;
    halt_cause_d  = halt_cause_q;
    overflow_d    = overflow_q;
    core_reset    = 1'b0;
    core_en       = 1'b0;
    push          = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        core_reset = (state_q == S_IDLE);
        if (start) begin
          state_d       = S_RESET;
          rst_cnt_d     = RW'(RESET_CYCLES - 1);
          cycle_count_d = '0;
          halt_cause_d  = 2'b00;
          overflow_d    = 1'b0;
        end
      end
      S_RESET: begin
        core_reset = 1'b1;
        core_en    = 1'b1;
        if (rst_cnt_q == '0) state_d = S_RUN;
        else                 rst_cnt_d = rst_cnt_q - RW'(1);
      end
      S_RUN: begin
        // Combinational from trace_ready so a full FIFO can still advance on a pop.
        core_en = !full || trace.trace_ready || WRAP_MODE;
        push    = core_en;
        if (push) begin
          cycle_count_d = cycle_count_q + XLEN'(1);
          if (instr == HALT_INSTR) begin
            halt_cause_d = 2'b01;
            state_d      = S_DONE;
          end else if (cycle_count_q == XLEN'(MAX_CYCLES - 1)) begin
            halt_cause_d = 2'b10;
            state_d      = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    drop = push && full && !pop;
    if (drop) overflow_d = 1'b1;
  end

  // A drop advances the read pointer in place of a pop, so occupancy stays at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop || drop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop && !drop) count_d = count_q + CW'(1);
    else if (pop && !push)     count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge pc_reset_n) begin
    if (!pc_reset_n) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      halt_cause_q  <= 2'b00;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_count_q <= cycle_count_d;
      halt_cause_q  <= halt_cause_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pc, instr, alu_result, wb_data};
  end

  assign head              = mem_q[rd_ptr_q];
  assign trace.trace_valid = !empty;
  assign trace.trace_pc    = empty ? '0 : head[4*XLEN-1:3*XLEN];
  assign trace.trace_instr = empty ? '0 : head[3*XLEN-1:2*XLEN];
  assign trace.trace_alu   = empty ? '0 : head[2*XLEN-1:XLEN];
  assign trace.trace_wb    = empty ? '0 : head[XLEN-1:0];

  assign busy        = (state_q == S_RESET) || (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign halt_cause  = halt_cause_q;
  assign cycle_count = cycle_count_q;
  assign trace_count = count_q;
  assign overflow    = overflow_q;
endmodule

// File: tb/tb_cpu_trace_ctrl.sv
// Bench for cpu_trace_ctrl: a stall-mode and a wrap-mode instance share stimulus and are
// compared every cycle against a record-history model of the run/trace rules.
module tb_cpu_trace_ctrl;
  localparam logic [31:0] HALT = 32'h0000000C;
  localparam int          HN   = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] pc, instr, alu, wb;
  logic        rdy [2];

  logic        cr0, ce0, bz0, dn0, ov0, cr1, ce1, bz1, dn1, ov1;
  logic [1:0]  hc0, hc1;
  logic [31:0] cc0, cc1;
  logic [2:0]  tc0, tc1;

  int checks = 0;
  int failures = 0;

  // Model: state 0 idle, 1 reset, 2 run, 3 done; FIFO is the window hd..tl of a history.
  int          ms [2], mrc [2], mcyc [2], mcause [2], hd [2], tl [2];
  bit          movf [2];
  logic [31:0] hpc [2][HN];
  logic [31:0] hin [2][HN];
  logic [31:0] hal [2][HN];
  logic [31:0] hwb [2][HN];

  always #5 clk = ~clk;

  cpu_trace_ctrl_if #(.XLEN(32)) tif0 ();
  cpu_trace_ctrl_if #(.XLEN(32)) tif1 ();
  assign tif0.trace_ready = rdy[0];
  assign tif1.trace_ready = rdy[1];

  cpu_trace_ctrl #(.XLEN(32), .DEPTH(4), .RESET_CYCLES(2), .MAX_CYCLES(8),
                   .HALT_INSTR(HALT), .WRAP_MODE(1'b0)) dut0 (
    .clk(clk), .pc_reset_n(rst_n), .start(start), .core_reset(cr0), .core_en(ce0),
    .pc(pc), .instr(instr), .alu_result(alu), .wb_data(wb), .trace(tif0.master),
    .busy(bz0), .done(dn0), .halt_cause(hc0), .cycle_count(cc0), .trace_count(tc0),
    .overflow(ov0));

  cpu_trace_ctrl #(.XLEN(32), .DEPTH(4), .RESET_CYCLES(2), .MAX_CYCLES(8),
                   .HALT_INSTR(HALT), .WRAP_MODE(1'b1)) dut1 (
    .clk(clk), .pc_reset_n(rst_n), .start(start), .core_reset(cr1), .core_en(ce1),
    .pc(pc), .instr(instr), .alu_result(alu), .wb_data(wb), .trace(tif1.master),
    .busy(bz1), .done(dn1), .halt_cause(hc1), .cycle_count(cc1), .trace_count(tc1),
    .overflow(ov1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_en(input int k);
    if (ms[k] == 1) return 1'b1;
    if (ms[k] == 2) return ((tl[k] - hd[k]) < 4) || rdy[k] || (k == 1);
    return 1'b0;
  endfunction

  function automatic logic [31:0] rnd_nh();
    logic [31:0] r;
    r = $urandom;
    if (r == HALT) r = 32'h1;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ms[k] = 0; mrc[k] = 0; mcyc[k] = 0; mcause[k] = 0; movf[k] = 1'b0;
      hd[k] = 0; tl[k] = 0;
    end
  endtask

  task automatic model_edge(input int k);
    int  occ;
    bit  en, pop, push;
    occ  = tl[k] - hd[k];
    en   = exp_en(k);
    pop  = (occ > 0) && rdy[k];
    push = (ms[k] == 2) && en;
    if (pop) hd[k]++;
    if (push) begin
      if (k == 1 && occ == 4 && !pop) begin
        hd[k]++;
        movf[k] = 1'b1;
      end
      hpc[k][tl[k] % HN] = pc;
      hin[k][tl[k] % HN] = instr;
      hal[k][tl[k] % HN] = alu;
      hwb[k][tl[k] % HN] = wb;
      tl[k]++;
    end
    case (ms[k])
      0, 3: if (start) begin
        ms[k] = 1; mrc[k] = 0; mcyc[k] = 0; mcause[k] = 0; movf[k] = 1'b0;
      end
      1: begin
        mrc[k]++;
        if (mrc[k] == 2) ms[k] = 2;
      end
      2: if (push) begin
        mcyc[k]++;
        if (instr == HALT) begin
          mcause[k] = 1; ms[k] = 3;
        end else if (mcyc[k] == 8) begin
          mcause[k] = 2; ms[k] = 3;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_inst(input int k, input logic cr, input logic ce, input logic bz,
                            input logic dn, input logic [1:0] hc, input logic [31:0] cc,
                            input logic [2:0] tc, input logic ov, input logic tv,
                            input logic [31:0] tp, input logic [31:0] ti,
                            input logic [31:0] ta, input logic [31:0] tw);
    int occ;
    bit ne;
    occ = tl[k] - hd[k];
    ne  = occ > 0;
    chk($sformatf("d%0d_core_reset", k), 32'(cr), 32'(ms[k] <= 1));
    chk($sformatf("d%0d_core_en", k), 32'(ce), 32'(exp_en(k)));
    chk($sformatf("d%0d_busy", k), 32'(bz), 32'(ms[k] == 1 || ms[k] == 2));
    chk($sformatf("d%0d_done", k), 32'(dn), 32'(ms[k] == 3));
    chk($sformatf("d%0d_halt_cause", k), 32'(hc), 32'(mcause[k]));
    chk($sformatf("d%0d_cycle_count", k), cc, 32'(mcyc[k]));
    chk($sformatf("d%0d_trace_count", k), 32'(tc), 32'(occ));
    chk($sformatf("d%0d_overflow", k), 32'(ov), 32'(movf[k]));
    chk($sformatf("d%0d_trace_valid", k), 32'(tv), 32'(ne));
    chk($sformatf("d%0d_trace_pc", k), tp, ne ? hpc[k][hd[k] % HN] : 32'h0);
    chk($sformatf("d%0d_trace_instr", k), ti, ne ? hin[k][hd[k] % HN] : 32'h0);
    chk($sformatf("d%0d_trace_alu", k), ta, ne ? hal[k][hd[k] % HN] : 32'h0);
    chk($sformatf("d%0d_trace_wb", k), tw, ne ? hwb[k][hd[k] % HN] : 32'h0);
  endtask

  task automatic check_all();
    check_inst(0, cr0, ce0, bz0, dn0, hc0, cc0, tc0, ov0, tif0.trace_valid,
               tif0.trace_pc, tif0.trace_instr, tif0.trace_alu, tif0.trace_wb);
    check_inst(1, cr1, ce1, bz1, dn1, hc1, cc1, tc1, ov1, tif1.trace_valid,
               tif1.trace_pc, tif1.trace_instr, tif1.trace_alu, tif1.trace_wb);
  endtask

  // Inputs are set at the falling edge; outputs checked 1 time unit later.
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    if (rst_n) begin
      model_edge(0);
      model_edge(1);
    end
    @(negedge clk);
  endtask

  task automatic set_core(input logic [31:0] p, input logic [31:0] i);
    pc = p; instr = i; alu = $urandom; wb = $urandom;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; rdy[0] = 1'b1; rdy[1] = 1'b1;
    set_core(32'h0, 32'h0);
    model_reset();
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic run and halt instruction on the 6th RUN cycle
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    for (int i = 0; i < 6; i++) begin
      set_core(32'(4 * i), (i == 5) ? HALT : rnd_nh());
      tick();
      if (i < 3) chk("basic_trace_pc", tif0.trace_pc, 32'(4 * i));
    end
    chk("halt_done", 32'(dn0), 32'd1);
    chk("halt_cause", 32'(hc0), 32'd1);
    chk("halt_cycles", cc0, 32'd6);
    chk("halt_core_en", 32'(ce0), 32'd0);
    chk("halt_record", tif0.trace_instr, HALT);
    set_core(32'h0, rnd_nh());
    tick(); tick();

    // Stall (instance 0) and wrap (instance 1) with the sink not ready
    rdy[0] = 1'b0; rdy[1] = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    for (int i = 0; i < 6; i++) begin
      set_core(32'(4 * i), (i == 5) ? HALT : rnd_nh());
      tick();
      if (i == 3) begin
        chk("stall_count", 32'(tc0), 32'd4);
        chk("stall_core_en", 32'(ce0), 32'd0);
      end
    end
    chk("stall_cycles_hold", cc0, 32'd4);
    chk("wrap_overflow", 32'(ov1), 32'd1);
    chk("wrap_count", 32'(tc1), 32'd4);
    chk("stall_no_overflow", 32'(ov0), 32'd0);
    set_core(32'd24, rnd_nh());
    rdy[0] = 1'b1;
    #1 chk("stall_pop_core_en", 32'(ce0), 32'd1);
    tick();
    rdy[0] = 1'b0;
    chk("stall_pop_count", 32'(tc0), 32'd4);
    chk("stall_pop_cycles", cc0, 32'd5);
    rdy[1] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("wrap_drain_pc", tif1.trace_pc, 32'(8 + 4 * j));
      tick();
    end

    // Cycle limit, then restart from DONE
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    n = 0;
    while (!(ms[0] == 3 && ms[1] == 3) && n < 60) begin
      set_core($urandom, rnd_nh());
      tick();
      n++;
    end
    chk("limit_prep_done", 32'(dn0 && dn1), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_cycles", cc0, 32'd0);
    chk("restart_cause", 32'(hc1), 32'd0);
    chk("restart_busy", 32'(bz0), 32'd1);
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      set_core(32'(4 * i), rnd_nh());
      tick();
    end
    chk("limit_done", 32'(dn0), 32'd1);
    chk("limit_cause", 32'(hc0), 32'd2);
    chk("limit_cycles", cc1, 32'd8);

    // Asynchronous reset mid-RUN during a pop
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      set_core(32'(4 * i), rnd_nh());
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_core_reset", 32'(cr0), 32'd1);
    chk("arst_core_en", 32'(ce0), 32'd0);
    chk("arst_trace_valid", 32'(tif0.trace_valid), 32'd0);
    chk("arst_trace_count", 32'(tc1), 32'd0);
    chk("arst_cycles", cc0, 32'd0);
    chk("arst_busy", 32'(bz1), 32'd0);
    chk("arst_done", 32'(dn0), 32'd0);
    model_reset();
    tick();
    rst_n = 1'b1;

    // Randomised traffic
    for (int c = 0; c < 400; c++) begin
      start  = ($urandom_range(7) == 0);
      rdy[0] = ($urandom_range(3) != 0);
      rdy[1] = ($urandom_range(2) == 0);
      set_core($urandom, ($urandom_range(15) == 0) ? HALT : rnd_nh());
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
